// File: rtl/cordic_post_pipe.sv
// CORDIC vectoring post-processor: folds the first-octant angle out to a full turn,
// adds a phase offset and applies gain compensation to the radius over three stages.
module cordic_post_pipe #(
  parameter int AW        = 16,
  parameter int RW        = 20,
  parameter int GAIN_COMP = 1,
  parameter int TW        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          in_valid,
  input  logic [AW-1:0] ai,
  input  logic [2:0]    q,
  input  logic [RW-1:0] ri,
  input  logic [AW-1:0] ang_ofs,
  input  logic [TW-1:0] tag_in,
  output logic          out_valid,
  output logic [AW-1:0] ao,
  output logic [RW-1:0] ro,
  output logic [TW-1:0] tag_out,
  output logic          ang_ovf
);

  localparam logic [AW-2:0] QUARTER = (AW-1)'(1) << (AW-2);
  localparam logic [AW-1:0] HALF    = AW'(1) << (AW-1);

  function automatic logic [RW-1:0] rad_s1(input logic [RW-1:0] x);
    case (GAIN_COMP)
      1:       rad_s1 = x - (x >> 3);
      2:       rad_s1 = (x >> 1) + (x >> 3);
      default: rad_s1 = x;
    endcase
  endfunction

  function automatic logic [RW-1:0] rad_s2(input logic [RW-1:0] r, input logic [RW-1:0] x);
    case (GAIN_COMP)
      1:       rad_s2 = r - (r >> 6);
      2:       rad_s2 = r - (x >> 6);
      default: rad_s2 = r;
    endcase
  endfunction

  function automatic logic [RW-1:0] rad_s3(input logic [RW-1:0] r, input logic [RW-1:0] x);
    case (GAIN_COMP)
      1:       rad_s3 = r - (r >> 9);
      2:       rad_s3 = r - (x >> 9);
      default: rad_s3 = r;
    endcase
  endfunction

  // A set top two residue bits mean the core overshot slightly below zero.
  logic          ovf_p0;
  logic [AW-2:0] a0_p0;
  assign ovf_p0 = ai[AW-2] & ai[AW-3];
  assign a0_p0  = ovf_p0 ? '0 : {1'b0, ai[AW-3:0]};

  logic          vld_p1, vld_p2, vld_p3;
  logic [AW-2:0] a1_p1;
  logic [AW-1:0] a2_p2;
  logic [1:0]    q_p1;
  logic          q_p2;
  logic [AW-1:0] ofs_p1, ofs_p2, ao_p3;
  logic [TW-1:0] tag_p1, tag_p2, tag_p3;
  logic          ovf_p1, ovf_p2, ovf_p3;
  logic [RW-1:0] r_p1, r_p2, r_p3;
  logic [RW-1:0] x_p1, x_p2;

  // 2^AW - a2 taken modulo 2^AW is simply the two's complement of a2.
  logic [AW-1:0] a3_p2;
  assign a3_p2 = q_p2 ? (AW'(0) - a2_p2) : a2_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0; vld_p2 <= 1'b0; vld_p3 <= 1'b0;
      a1_p1  <= '0;   a2_p2  <= '0;   ao_p3  <= '0;
      q_p1   <= '0;   q_p2   <= 1'b0;
      ofs_p1 <= '0;   ofs_p2 <= '0;
      tag_p1 <= '0;   tag_p2 <= '0;   tag_p3 <= '0;
      ovf_p1 <= 1'b0; ovf_p2 <= 1'b0; ovf_p3 <= 1'b0;
      r_p1   <= '0;   r_p2   <= '0;   r_p3   <= '0;
      x_p1   <= '0;   x_p2   <= '0;
    end else if (ena) begin
      // stage 1: reflect about 45 deg, first radius step
      vld_p1 <= in_valid;
      a1_p1  <= q[0] ? (QUARTER - a0_p0) : a0_p0;
      q_p1   <= q[2:1];
      ofs_p1 <= ang_ofs;
      tag_p1 <= tag_in;
      ovf_p1 <= ovf_p0;
      r_p1   <= rad_s1(ri);
      x_p1   <= ri;
      // stage 2: reflect about 90 deg, second radius step
      vld_p2 <= vld_p1;
      a2_p2  <= q_p1[0] ? (HALF - {1'b0, a1_p1}) : {1'b0, a1_p1};
      q_p2   <= q_p1[1];
      ofs_p2 <= ofs_p1;
      tag_p2 <= tag_p1;
      ovf_p2 <= ovf_p1;
      r_p2   <= rad_s2(r_p1, x_p1);
      x_p2   <= x_p1;
      // stage 3: reflect about 180 deg, add offset, final radius step
      vld_p3 <= vld_p2;
      ao_p3  <= a3_p2 + ofs_p2;
      tag_p3 <= tag_p2;
      ovf_p3 <= ovf_p2;
      r_p3   <= rad_s3(r_p2, x_p2);
    end
  end

  assign out_valid = vld_p3;
  assign ao        = ao_p3;
  assign ro        = r_p3;
  assign tag_out   = tag_p3;
  assign ang_ovf   = ovf_p3;

endmodule
